multi_edge_detect: RTL and testbench
====================================

# multi_edge_detect

Parametrised multi-channel edge detector with per-channel mode select, optional input synchroniser, sticky event flags and saturating edge counters. Each channel runs its own four-state Moore machine and emits a registered one-cycle pulse on qualified rising and/or falling edges. It sits between raw asynchronous or slow-domain status lines and the interrupt/status logic that consumes single-cycle event strobes.

## Interface

- WIDTH, 8, number of independent channels (1..32)
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (0..4; 0 = input used directly)
- CNT_W, 8, width of each per-channel edge counter (1..16)

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in  input  WIDTH  raw channel inputs
- mode  input  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clr  input  WIDTH  per-channel clear of sticky flag and counter, one cycle
- pulse  output  WIDTH  registered one-cycle strobe per qualified edge
- level  output  WIDTH  registered debounced level (1 in HIGH/IDLE_HIGH)
- sticky  output  WIDTH  latched "edge seen" flag per channel
- count  output  WIDTH*CNT_W  saturating qualified-edge count, channel i at [CNT_W*i +: CNT_W]
- any_event  output  1  OR of pulse[WIDTH-1:0]

## Operation

- Synchroniser: SYNC_STAGES flops per channel; output s[i]. SYNC_STAGES=0: s[i] = in[i].
- Per-channel one-hot FSM, states IDLE_LOW, HIGH, IDLE_HIGH, LOW:
  - IDLE_LOW: s=1 -> HIGH, else stay.
  - HIGH: unconditionally -> IDLE_HIGH.
  - IDLE_HIGH: s=0 -> LOW, else stay.
  - LOW: unconditionally -> IDLE_LOW.
- FSM always tracks the input regardless of mode; mode only gates outputs.
- Rise event = present state HIGH; fall event = present state LOW.
- Qualification: rise counts if mode bit 0 set; fall counts if mode bit 1 set; mode 00 suppresses both. Mode sampled on the same edge that registers pulse.
- pulse[i] <= qualified event; level[i] <= present state in {HIGH, IDLE_HIGH}.
- sticky[i]: set on qualified event; cleared by clr[i]; set and clr same cycle -> sticky = 1.
- count[i]: +1 per qualified event, saturates at 2^CNT_W-1; clr[i] -> 0; clr and event same cycle -> 1.
- Alternation guaranteed: per channel, rise and fall events strictly alternate (before mode gating). A level held for only one sample while in HIGH/LOW may be absorbed; the following opposite edge is then also absorbed, preserving alternation.
- Channels fully independent; no cross-channel interaction except any_event.

## Timing

- Reset: sync flops 0, all FSMs IDLE_LOW, pulse/level/sticky/count/any_event = 0.
- Latency: in[i] first sampled high at edge E0 -> pulse[i] high for exactly one cycle following edge E0+SYNC_STAGES+1; level[i] rises at the same edge.
- Minimum guaranteed detection: each level held ≥2 consecutive samples.
- Input high at reset release: reported as a rise after normal latency.
- Reset asserted mid-operation: takes effect at the next edge; pending pulses dropped, counters and sticky cleared.
- any_event is combinational from pulse registers, same cycle as pulse.

## Test plan

- Reset then in[0] 0->1 held 5 cycles, mode[1:0]=11, SYNC_STAGES=2 -> pulse[0] single cycle 3 cycles after first high sample, level[0]=1 same edge, count[0]=1, sticky[0]=1.
- Channel 1 mode=01, in[1] toggles 1,0,1,0 each held 4 cycles -> exactly 2 pulses, count[1]=2; same with mode=10 -> 2 pulses on falls; mode=00 -> no pulse, count 0, level still tracks.
- in[2] single-cycle high, single-cycle low, single-cycle high -> rise reported, fall and second rise absorbed, rise/fall alternation never violated across 1000 random cycles.
- CNT_W=2, 5 qualified edges -> count saturates at 3; clr asserted on the cycle of a pulse -> count=1, sticky=1.
- All WIDTH channels edge simultaneously with mixed modes -> pulses only on enabled channels, any_event high one cycle, no cross-talk.
- Reset asserted while level=1 and count=7 -> next cycle all outputs 0; in still high after release -> new rise pulse reported.

Source files
------------

// File: rtl/multi_edge_detect_if.sv
// multi_edge_detect_if
//   Bundles the per-channel inputs and event/status outputs of
//   multi_edge_detect so producers and consumers share one connection.
//
//   in        raw channel inputs (WIDTH)
//   mode      per-channel mode, [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr       per-channel one-cycle clear of sticky flag and counter
//   pulse     registered one-cycle strobe per qualified edge
//   level     registered debounced level
//   sticky    latched "edge seen" flag
//   count     saturating qualified-edge counts, channel i at [CNT_W*i +: CNT_W]
//   any_event OR of pulse
//
//   master: drives in/mode/clr and observes the outputs.
//   slave : the detector side.
interface multi_edge_detect_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0]       in;
  logic [2*WIDTH-1:0]     mode;
  logic [WIDTH-1:0]       clr;
  logic [WIDTH-1:0]       pulse;
  logic [WIDTH-1:0]       level;
  logic [WIDTH-1:0]       sticky;
  logic [WIDTH*CNT_W-1:0] count;
  logic                   any_event;

  modport master (
    output in, mode, clr,
    input  pulse, level, sticky, count, any_event
  );

  modport slave (
    input  in, mode, clr,
    output pulse, level, sticky, count, any_event
  );
endinterface

// File: rtl/multi_edge_detect.sv
// multi_edge_detect
//   Multi-channel edge detector. Each channel has an optional flop
//   synchroniser, a four-state one-hot Moore machine that tracks the
//   synchronised level, and registered pulse/level/sticky/count outputs.
//   Mode only gates the outputs; the state machine always follows the input.
//
//   Parameters
//     WIDTH       number of channels (1..32)
//     SYNC_STAGES synchroniser depth (0..4, 0 = input used directly)
//     CNT_W       per-channel counter width (1..16)
//
//   Ports
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    multi_edge_detect_if slave: in, mode, clr -> pulse, level,
//            sticky, count, any_event
module multi_edge_detect #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  multi_edge_detect_if.slave bus
);

  localparam logic [3:0] ST_IDLE_LOW  = 4'b0001;
  localparam logic [3:0] ST_HIGH      = 4'b0010;
  localparam logic [3:0] ST_IDLE_HIGH = 4'b0100;
  localparam logic [3:0] ST_LOW       = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchronised channel levels seen by the state machines.
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] pulse_vec;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = bus.in;
  end else begin : g_sync
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
          stage_q[k] <= '0;
        end
      end else begin
        stage_q[0] <= bus.in;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign s = stage_q[SYNC_STAGES-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             rise_evt;
    logic             fall_evt;
    logic             qual_evt;
    logic             pulse_q;
    logic             level_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    // HIGH and LOW last exactly one cycle whatever the input does, so a
    // one-sample glitch right after an edge is ignored and the following
    // opposite edge is swallowed with it; rise/fall therefore alternate.
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE_LOW:  if (s[i])  state_d = ST_HIGH;
        ST_HIGH:                 state_d = ST_IDLE_HIGH;
        ST_IDLE_HIGH: if (!s[i]) state_d = ST_LOW;
        ST_LOW:                  state_d = ST_IDLE_LOW;
        default:                 state_d = ST_IDLE_LOW;
      endcase
    end

    assign rise_evt = (state_q == ST_HIGH);
    assign fall_evt = (state_q == ST_LOW);
    assign qual_evt = (rise_evt & bus.mode[2*i]) | (fall_evt & bus.mode[2*i+1]);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE_LOW;
        pulse_q  <= 1'b0;
        level_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        state_q  <= state_d;
        pulse_q  <= qual_evt;
        level_q  <= rise_evt | (state_q == ST_IDLE_HIGH);
        // An event in the clearing cycle wins over the clear.
        sticky_q <= qual_evt | (sticky_q & ~bus.clr[i]);
        if (bus.clr[i]) begin
          cnt_q <= qual_evt ? CNT_ONE : '0;
        end else if (qual_evt && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end

    assign pulse_vec[i]                = pulse_q;
    assign bus.level[i]                = level_q;
    assign bus.sticky[i]               = sticky_q;
    assign bus.count[CNT_W*i +: CNT_W] = cnt_q;
  end

  assign bus.pulse     = pulse_vec;
  assign bus.any_event = |pulse_vec;

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect
//   Drives two detector configurations side by side:
//     dut0: WIDTH=8, SYNC_STAGES=2, CNT_W=8
//     dut1: WIDTH=4, SYNC_STAGES=0, CNT_W=2
//   Every cycle a behavioural model pushes the expected outputs of both
//   instances into a queue before the clock edge; they are popped and
//   compared after the edge. Directed constant checks cover latency,
//   mode gating, absorption, saturation, clear/event collisions and reset.
module tb_multi_edge_detect;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multi_edge_detect_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
  multi_edge_detect_if #(.WIDTH(4), .CNT_W(2)) bus1 ();

  multi_edge_detect #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  multi_edge_detect #(.WIDTH(4), .SYNC_STAGES(0), .CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    int          d;
    logic [7:0]  pulse;
    logic [7:0]  level;
    logic [7:0]  sticky;
    logic [63:0] count;
    logic        any;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int P_W [2] = '{8, 4};
  int P_S [2] = '{2, 0};
  int P_C [2] = '{8, 2};

  // Model state: det is the debounced level, hold marks the single cycle
  // after a detected transition (the event cycle) during which input is ignored.
  bit m_sh     [2][8][4];
  bit m_det    [2][8];
  bit m_hold   [2][8];
  bit m_pulse  [2][8];
  bit m_level  [2][8];
  bit m_sticky [2][8];
  int m_cnt    [2][8];

  int pc0 [8];
  bit alt_en = 1'b0;
  bit last_dir [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step(input int d, input logic [7:0] iv, input logic [15:0] mv,
                            input logic [7:0] cv);
    exp_t e;
    bit   s;
    bit   qual;
    int   mx;
    mx       = (1 << P_C[d]) - 1;
    e.d      = d;
    e.pulse  = '0;
    e.level  = '0;
    e.sticky = '0;
    e.count  = '0;
    for (int i = 0; i < P_W[d]; i++) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) m_sh[d][i][k] = 1'b0;
        m_det[d][i]    = 1'b0;
        m_hold[d][i]   = 1'b0;
        m_pulse[d][i]  = 1'b0;
        m_level[d][i]  = 1'b0;
        m_sticky[d][i] = 1'b0;
        m_cnt[d][i]    = 0;
      end else begin
        s    = (P_S[d] == 0) ? iv[i] : m_sh[d][i][P_S[d]-1];
        qual = (m_hold[d][i] &&  m_det[d][i] && mv[2*i]) ||
               (m_hold[d][i] && !m_det[d][i] && mv[2*i+1]);
        m_pulse[d][i]  = qual;
        m_level[d][i]  = m_det[d][i];
        m_sticky[d][i] = qual || (m_sticky[d][i] && !cv[i]);
        if (cv[i]) m_cnt[d][i] = qual ? 1 : 0;
        else if (qual && m_cnt[d][i] < mx) m_cnt[d][i] = m_cnt[d][i] + 1;
        if (m_hold[d][i]) begin
          m_hold[d][i] = 1'b0;
        end else if (s != m_det[d][i]) begin
          m_det[d][i]  = s;
          m_hold[d][i] = 1'b1;
        end
        for (int k = P_S[d] - 1; k > 0; k--) m_sh[d][i][k] = m_sh[d][i][k-1];
        if (P_S[d] > 0) m_sh[d][i][0] = iv[i];
      end
      e.pulse[i]  = m_pulse[d][i];
      e.level[i]  = m_level[d][i];
      e.sticky[i] = m_sticky[d][i];
      e.count     = e.count | (64'(m_cnt[d][i]) << (i * P_C[d]));
    end
    e.any = |e.pulse;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t        e;
    logic [7:0]  op, ol, os;
    logic [63:0] oc;
    logic        oa;
    model_step(0, bus0.in, bus0.mode, bus0.clr);
    model_step(1, {4'b0, bus1.in}, {8'b0, bus1.mode}, {4'b0, bus1.clr});
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.d == 0) begin
        op = bus0.pulse; ol = bus0.level; os = bus0.sticky;
        oc = 64'(bus0.count); oa = bus0.any_event;
      end else begin
        op = {4'b0, bus1.pulse}; ol = {4'b0, bus1.level}; os = {4'b0, bus1.sticky};
        oc = 64'(bus1.count); oa = bus1.any_event;
      end
      chk($sformatf("d%0d_pulse", e.d),  64'(op), 64'(e.pulse));
      chk($sformatf("d%0d_level", e.d),  64'(ol), 64'(e.level));
      chk($sformatf("d%0d_sticky", e.d), 64'(os), 64'(e.sticky));
      chk($sformatf("d%0d_count", e.d),  oc,      e.count);
      chk($sformatf("d%0d_any", e.d),    64'(oa), 64'(e.any));
    end
    for (int i = 0; i < 8; i++) begin
      if (bus0.pulse[i] === 1'b1) begin
        pc0[i]++;
        if (alt_en) begin
          chk($sformatf("alt_ch%0d", i), 64'(bus0.level[i]), 64'(!last_dir[i]));
          last_dir[i] = bus0.level[i];
        end
      end
    end
  endtask

  // Clears channel ch, sets its mode, then drives 1,0,1,0 each held 4 cycles.
  task automatic toggle_seq(input int ch, input logic [1:0] md, input int npulse);
    bus0.mode[2*ch +: 2] = md;
    bus0.clr[ch] = 1'b1;
    cycle();
    bus0.clr = '0;
    pc0[ch] = 0;
    for (int t = 0; t < 4; t++) begin
      bus0.in[ch] = (t % 2 == 0);
      for (int k = 0; k < 4; k++) begin
        cycle();
        if (t == 0 && k == 3) chk($sformatf("tog_level_ch%0d", ch), 64'(bus0.level[ch]), 64'd1);
      end
    end
    repeat (6) cycle();
    chk($sformatf("tog_pulses_m%0d", md), 64'(pc0[ch]), 64'(npulse));
    chk($sformatf("tog_count_m%0d", md), 64'(bus0.count[8*ch +: 8]), 64'(npulse));
  endtask

  initial begin
    reset     = 1'b1;
    bus0.in   = '0; bus0.mode = '0; bus0.clr = '0;
    bus1.in   = '0; bus1.mode = '0; bus1.clr = '0;
    for (int i = 0; i < 8; i++) begin pc0[i] = 0; last_dir[i] = 1'b0; end

    repeat (3) cycle();
    chk("rst_count0", bus0.count, 64'd0);
    chk("rst_level0", 64'(bus0.level), 64'd0);
    reset = 1'b0;
    repeat (2) cycle();

    // Latency: first high sample at call 0, pulse registered at call 3.
    bus0.mode = 16'h0007;
    bus0.in   = 8'h01;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("lat_pulse_k%0d", k), 64'(bus0.pulse[0]), 64'(k == 3));
      chk($sformatf("lat_level_k%0d", k), 64'(bus0.level[0]), 64'(k >= 3));
      if (k == 3) begin
        chk("lat_count", 64'(bus0.count[7:0]), 64'd1);
        chk("lat_sticky", 64'(bus0.sticky[0]), 64'd1);
      end
    end
    bus0.in = 8'h00;
    repeat (6) cycle();
    chk("fall_count0", 64'(bus0.count[7:0]), 64'd2);

    // Mode gating on channel 1.
    toggle_seq(1, 2'b01, 2);
    toggle_seq(1, 2'b10, 2);
    toggle_seq(1, 2'b00, 0);

    // Absorption: 1,0,1 single samples then low -> one rise, one fall.
    bus0.mode[5:4] = 2'b11;
    pc0[2] = 0;
    bus0.in[2] = 1'b1; cycle();
    bus0.in[2] = 1'b0; cycle();
    bus0.in[2] = 1'b1; cycle();
    bus0.in[2] = 1'b0;
    repeat (8) cycle();
    chk("absorb_pulses", 64'(pc0[2]), 64'd2);
    chk("absorb_count", 64'(bus0.count[23:16]), 64'd2);

    // Saturation on the 2-bit counter, then clear colliding with an event.
    bus1.mode = 8'h03;
    for (int t = 0; t < 5; t++) begin
      bus1.in[0] = (t % 2 == 0);
      repeat (3) cycle();
    end
    chk("sat_count", 64'(bus1.count[1:0]), 64'd3);
    bus1.in[0] = 1'b0;
    cycle();
    bus1.clr[0] = 1'b1;
    cycle();
    bus1.clr = '0;
    chk("clr_evt_pulse", 64'(bus1.pulse[0]), 64'd1);
    chk("clr_evt_count", 64'(bus1.count[1:0]), 64'd1);
    chk("clr_evt_sticky", 64'(bus1.sticky[0]), 64'd1);
    cycle();
    bus1.clr[0] = 1'b1;
    cycle();
    bus1.clr = '0;
    chk("clr_count", 64'(bus1.count[1:0]), 64'd0);
    chk("clr_sticky", 64'(bus1.sticky[0]), 64'd0);

    // All channels edge together with mixed modes 00,01,10,11 repeating.
    bus0.mode = 16'hE4E4;
    bus1.mode = 8'hE4;
    bus0.in   = 8'hFF;
    bus1.in   = 4'hF;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("all_rise0_k%0d", k), 64'(bus0.pulse), (k == 3) ? 64'hAA : 64'h0);
      chk($sformatf("all_rise_any_k%0d", k), 64'(bus0.any_event), 64'(k == 3));
      chk($sformatf("all_rise1_k%0d", k), 64'(bus1.pulse), (k == 1) ? 64'hA : 64'h0);
    end
    bus0.in = 8'h00;
    bus1.in = 4'h0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("all_fall0_k%0d", k), 64'(bus0.pulse), (k == 3) ? 64'hCC : 64'h0);
      chk($sformatf("all_fall1_k%0d", k), 64'(bus1.pulse), (k == 1) ? 64'hC : 64'h0);
    end
    repeat (2) cycle();

    // Random activity with every edge enabled; alternation checked per pulse.
    bus0.mode = 16'hFFFF;
    bus1.mode = 8'hFF;
    for (int i = 0; i < 8; i++) last_dir[i] = bus0.level[i];
    alt_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      bus0.in  = bus0.in ^ 8'($urandom & $urandom & $urandom);
      bus1.in  = bus1.in ^ 4'($urandom & $urandom);
      bus0.clr = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
      bus1.clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      cycle();
    end
    alt_en   = 1'b0;
    bus0.in  = '0; bus1.in = '0;
    bus0.clr = '0; bus1.clr = '0;
    repeat (8) cycle();

    // Build count=7, level=1 on channel 4, then reset mid-operation.
    bus0.clr = 8'hFF;
    cycle();
    bus0.clr = '0;
    for (int t = 0; t < 7; t++) begin
      bus0.in[4] = (t % 2 == 0);
      repeat (4) cycle();
    end
    repeat (5) cycle();
    chk("pre_rst_count4", 64'(bus0.count[39:32]), 64'd7);
    chk("pre_rst_level4", 64'(bus0.level[4]), 64'd1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_pulse", 64'(bus0.pulse), 64'd0);
    chk("mid_rst_level", 64'(bus0.level), 64'd0);
    chk("mid_rst_sticky", 64'(bus0.sticky), 64'd0);
    chk("mid_rst_count", bus0.count, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("post_rst_pulse_k%0d", k), 64'(bus0.pulse[4]), 64'(k == 3));
    end
    chk("post_rst_count4", 64'(bus0.count[39:32]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
